// File: rtl/aes_dec_top.sv
// aes_dec_top -- N-lane AES-128 inverse cipher, one inverse round per clock.
//
// All lanes run in lock-step under one shared sequencer. A start accepted in
// IDLE or DONE captures every lane's ciphertext and key. The round keys are
// then expanded forward into per-lane storage over 10 cycles, followed by one
// whitening cycle and 10 inverse rounds that walk the keys in reverse order.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst              synchronous active-high reset, aborts any operation
//   start            request, only honoured in IDLE or DONE
//   cipher_text      N x 128-bit ciphertext, lane i at [128*i +: 128]
//   cipher_key       N x 128-bit AES-128 (encryption) key, same packing
//   done             high while plain_text holds a finished result
//   completed_round  thermometer, bit r-1 set once inverse round r is done
//   plain_text       N x 128-bit result, held until next accepted start/reset
module aes_dec_top #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [128*N-1:0] cipher_text,
   input  logic [128*N-1:0] cipher_key,
   output logic             done,
   output logic [9:0]       completed_round,
   output logic [128*N-1:0] plain_text
);

   typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_DONE} state_t;

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x1, x2, x3, x4, x5, x6, x7;
      x1 = xtime(a);  x2 = xtime(x1); x3 = xtime(x2); x4 = xtime(x3);
      x5 = xtime(x4); x6 = xtime(x5); x7 = xtime(x6);
      return ({8{b[0]}} & a)  ^ ({8{b[1]}} & x1) ^ ({8{b[2]}} & x2) ^
             ({8{b[3]}} & x3) ^ ({8{b[4]}} & x4) ^ ({8{b[5]}} & x5) ^
             ({8{b[6]}} & x6) ^ ({8{b[7]}} & x7);
   endfunction

   // Inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p, r;
      p = gf_mul(a, a);
      r = p;
      p = gf_mul(p, p); r = gf_mul(r, p);
      p = gf_mul(p, p); r = gf_mul(r, p);
      p = gf_mul(p, p); r = gf_mul(r, p);
      p = gf_mul(p, p); r = gf_mul(r, p);
      p = gf_mul(p, p); r = gf_mul(r, p);
      p = gf_mul(p, p); r = gf_mul(r, p);
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y;
      y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

   // ---------------- shared sequencer ----------------
   state_t     r_fsm, w_fsm_next;
   logic [3:0] r_cnt;            // key index in KEYEXP, round number in ROUND
   logic [9:0] r_cr;
   logic       r_done;
   logic       w_load, w_kexp, w_init, w_round, w_last;
   logic [7:0] w_rcon;

   always_ff @(posedge clk) begin
      if (rst) r_fsm <= S_IDLE;
      else     r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      w_load     = 1'b0;
      w_kexp     = 1'b0;
      w_init     = 1'b0;
      w_round    = 1'b0;
      w_last     = 1'b0;
      case (r_fsm)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_load     = 1'b1;
               w_fsm_next = S_KEYEXP;
            end
         end
         S_KEYEXP: begin
            w_kexp = 1'b1;
            if (r_cnt == 4'd10) w_fsm_next = S_INIT;
         end
         S_INIT: begin
            w_init     = 1'b1;
            w_fsm_next = S_ROUND;
         end
         S_ROUND: begin
            w_round = 1'b1;
            if (r_cnt == 4'd10) begin
               w_last     = 1'b1;
               w_fsm_next = S_DONE;
            end
         end
         default: w_fsm_next = S_IDLE;
      endcase
   end

   always_comb begin
      case (r_cnt)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= 4'd0;
         r_cr   <= 10'd0;
         r_done <= 1'b0;
      end else if (w_load) begin
         r_cnt  <= 4'd1;
         r_cr   <= 10'd0;
         r_done <= 1'b0;
      end else if (w_kexp) begin
         r_cnt <= r_cnt + 4'd1;
      end else if (w_init) begin
         r_cnt <= 4'd1;
      end else if (w_round) begin
         r_cnt <= r_cnt + 4'd1;
         // rounds finish strictly in order, so shifting in a 1 sets bit r-1
         r_cr  <= {r_cr[8:0], 1'b1};
         if (w_last) r_done <= 1'b1;
      end
   end

   assign done            = r_done;
   assign completed_round = r_cr;

   // ---------------- per-lane datapath ----------------
   genvar gi, gj, gc;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [127:0] r_rk [0:10];
         logic [127:0] r_ct, r_st, r_pt;
         logic [127:0] w_kprev, w_knext, w_rk_sel, w_ark, w_imc, w_rnd;
         logic [31:0]  w_sub;

         // forward expansion: rk[k] from rk[k-1], k = r_cnt
         assign w_kprev = r_rk[r_cnt - 4'd1];
         assign w_sub   = {sbox(w_kprev[23:16]) ^ w_rcon, sbox(w_kprev[15:8]),
                           sbox(w_kprev[7:0]), sbox(w_kprev[31:24])};
         assign w_knext[127:96] = w_kprev[127:96] ^ w_sub;
         assign w_knext[95:64]  = w_kprev[95:64]  ^ w_knext[127:96];
         assign w_knext[63:32]  = w_kprev[63:32]  ^ w_knext[95:64];
         assign w_knext[31:0]   = w_kprev[31:0]   ^ w_knext[63:32];

         // inverse round r uses rk[10-r]
         assign w_rk_sel = r_rk[4'd10 - r_cnt];

         // InvShiftRows folded into the byte wiring: row R rotates right by R
         for (gj = 0; gj < 16; gj++) begin : g_byte
            localparam int R   = gj % 4;
            localparam int C   = gj / 4;
            localparam int SRC = R + 4 * ((C + 4 - R) % 4);
            assign w_ark[127-8*gj -: 8] = inv_sbox(r_st[127-8*SRC -: 8]) ^ w_rk_sel[127-8*gj -: 8];
         end

         for (gc = 0; gc < 4; gc++) begin : g_col
            assign w_imc[127-32*gc -: 32] = inv_mix_col(w_ark[127-32*gc -: 32]);
         end

         assign w_rnd = w_last ? w_ark : w_imc;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_rk <= '{default: '0};
               r_ct <= '0;
               r_st <= '0;
               r_pt <= '0;
            end else begin
               if (w_load) begin
                  r_ct    <= cipher_text[128*gi +: 128];
                  r_rk[0] <= cipher_key[128*gi +: 128];
               end
               if (w_kexp) r_rk[r_cnt] <= w_knext;
               if (w_init) r_st <= r_ct ^ r_rk[10];
               if (w_round) begin
                  r_st <= w_rnd;
                  if (w_last) r_pt <= w_rnd;
               end
            end
         end

         assign plain_text[128*gi +: 128] = r_pt;
      end
   endgenerate

endmodule

// File: tb/tb_aes_dec_top.sv
// tb_aes_dec_top -- directed bench for aes_dec_top (N=4) using FIPS-197 and
// SP800-38A known-answer vectors, with cycle-exact handshake/round checks.
module tb_aes_dec_top;
   localparam int N = 4;

   localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] S1_CT = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] S1_PT = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] S2_CT = 128'hf5d3d58503b9699de785895a96fdbaaf;
   localparam logic [127:0] S2_PT = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] Z_K   = 128'h0;
   localparam logic [127:0] Z_PT  = 128'h0;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [128*N-1:0] ct;
   logic [128*N-1:0] key;
   logic             done;
   logic [9:0]       cr;
   logic [128*N-1:0] pt;
   logic [128*N-1:0] pt_model;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_dec_top #(.N(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cipher_text     (ct),
      .cipher_key      (key),
      .done            (done),
      .completed_round (cr),
      .plain_text      (pt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_lanes(input logic [127:0] c0, input logic [127:0] c1,
                            input logic [127:0] c2, input logic [127:0] c3,
                            input logic [127:0] k0, input logic [127:0] k1,
                            input logic [127:0] k2, input logic [127:0] k3);
      ct  = {c3, c2, c1, c0};
      key = {k3, k2, k1, k0};
   endtask

   // Starts an operation at the next edge (E0) and checks every cycle up to
   // E21. busy1/busy2 name edges at which a stray start with corrupted
   // inputs is presented (0 = none).
   task automatic run_op(input string tag, input logic [511:0] exp_pt,
                         input int busy1, input int busy2);
      logic [9:0] exp_cr;
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("%s_accept_done", tag), done, 1'b0);
      check($sformatf("%s_accept_cr", tag), cr, 10'h000);
      check($sformatf("%s_accept_pt", tag), pt, pt_model);
      for (int k = 1; k <= 21; k++) begin
         if (k == busy1 || k == busy2) begin
            start = 1'b1;
            ct    = ~ct;
            key   = key ^ {16{32'hdeadbeef}};
         end
         step();
         start  = 1'b0;
         exp_cr = (k >= 12) ? 10'((1 << (k - 11)) - 1) : 10'h000;
         check($sformatf("%s_done_e%0d", tag, k), done, (k == 21));
         check($sformatf("%s_cr_e%0d", tag, k), cr, exp_cr);
         check($sformatf("%s_pt_e%0d", tag, k), pt, (k == 21) ? exp_pt : pt_model);
      end
      pt_model = exp_pt;
      $display("op %s: plain_text=%h done=%0d completed_round=%h", tag, pt, done, cr);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      ct       = '0;
      key      = '0;
      pt_model = '0;
      step();
      step();
      check("rst_done", done, 1'b0);
      check("rst_cr", cr, 10'h000);
      check("rst_pt", pt, '0);
      rst = 1'b0;
      step();

      // Mixed lanes: 0,2 = FIPS-197 C.1, 1,3 = FIPS-197 App. B
      set_lanes(C1_CT, B_CT, C1_CT, B_CT, C1_K, B_K, C1_K, B_K);
      run_op("mixed", {B_PT, C1_PT, B_PT, C1_PT}, 0, 0);

      // DONE holds its result while start stays low
      for (int k = 0; k < 3; k++) step();
      check("hold_done", done, 1'b1);
      check("hold_cr", cr, 10'h3ff);
      check("hold_pt", pt, pt_model);

      // Start from DONE, with ignored starts at E5 and E15
      set_lanes(S1_CT, S2_CT, Z_CT, C1_CT, B_K, B_K, Z_K, C1_K);
      run_op("busy", {C1_PT, Z_PT, S2_PT, S1_PT}, 5, 15);

      // Reset sampled at E14 aborts the operation
      set_lanes(B_CT, B_CT, B_CT, B_CT, B_K, B_K, B_K, B_K);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 13; k++) step();
      check("midop_cr_e13", cr, 10'h003);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_done", done, 1'b0);
      check("midrst_cr", cr, 10'h000);
      check("midrst_pt", pt, '0);
      pt_model = '0;
      for (int k = 0; k < 25; k++) step();
      check("midrst_idle_done", done, 1'b0);
      check("midrst_idle_cr", cr, 10'h000);
      $display("op midrst: aborted at E14, plain_text=%h", pt);
      set_lanes(C1_CT, C1_CT, C1_CT, C1_CT, C1_K, C1_K, C1_K, C1_K);
      run_op("after_rst", {C1_PT, C1_PT, C1_PT, C1_PT}, 0, 0);

      // Back-to-back with start held high: one operation every 22 cycles.
      // Inputs change right after E0; the second operation must pick them up.
      set_lanes(Z_CT, S1_CT, B_CT, S2_CT, Z_K, B_K, B_K, B_K);
      start = 1'b1;
      step();
      set_lanes(B_CT, C1_CT, S2_CT, Z_CT, B_K, C1_K, B_K, Z_K);
      for (int k = 1; k <= 20; k++) step();
      check("b2b1_e20_done", done, 1'b0);
      step();
      check("b2b1_done", done, 1'b1);
      check("b2b1_pt", pt, {S2_PT, B_PT, S1_PT, Z_PT});
      pt_model = {S2_PT, B_PT, S1_PT, Z_PT};
      $display("op b2b1: plain_text=%h", pt);
      step();
      check("b2b2_accept_done", done, 1'b0);
      check("b2b2_accept_cr", cr, 10'h000);
      check("b2b2_accept_pt", pt, pt_model);
      for (int k = 1; k <= 20; k++) step();
      check("b2b2_e20_done", done, 1'b0);
      step();
      check("b2b2_done", done, 1'b1);
      check("b2b2_pt", pt, {Z_PT, S2_PT, C1_PT, B_PT});
      pt_model = {Z_PT, S2_PT, C1_PT, B_PT};
      $display("op b2b2: plain_text=%h", pt);
      start = 1'b0;
      step();

      // rst and start together in DONE: reset wins, nothing starts
      start = 1'b1;
      rst   = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      check("rststart_done", done, 1'b0);
      check("rststart_cr", cr, 10'h000);
      check("rststart_pt", pt, '0);
      for (int k = 0; k < 25; k++) step();
      check("rststart_idle_done", done, 1'b0);
      check("rststart_idle_pt", pt, '0);
      $display("op rststart: done=%0d plain_text=%h", done, pt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
